// File: rtl/user_event_queue_pkg.sv
// Shared definitions for the user event queue: event codes, button indices and arbitration order.
// Event codes reuse the codebase-wide `EV_* defines; they are only defined here if nothing else has.
`ifndef EV_LEFT
`define EV_LEFT     3'd1
`define EV_RIGHT    3'd2
`define EV_DOWN     3'd3
`define EV_ROTATE   3'd4
`define EV_NEW_GAME 3'd5
`endif

package user_event_queue_pkg;

    localparam int EV_W = 3;
    typedef logic [EV_W-1:0] ev_code_t;

    localparam int BTN_LEFT     = 0;
    localparam int BTN_RIGHT    = 1;
    localparam int BTN_DOWN     = 2;
    localparam int BTN_ROTATE   = 3;
    localparam int BTN_NEW_GAME = 4;
    localparam int BTN_CNT      = 5;

    // Highest priority first.
    localparam int BTN_PRIO [BTN_CNT] = '{BTN_NEW_GAME, BTN_ROTATE, BTN_DOWN, BTN_LEFT, BTN_RIGHT};

    localparam ev_code_t BTN_CODE [BTN_CNT] = '{`EV_LEFT, `EV_RIGHT, `EV_DOWN, `EV_ROTATE, `EV_NEW_GAME};

    // Buttons eligible for auto-repeat: LEFT, RIGHT, DOWN.
    localparam logic [BTN_CNT-1:0] REPEAT_MASK = 5'b00111;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_PERIOD
    } rep_state_t;

endpackage

// File: rtl/user_event_queue_if.sv
// Consumer-side event handshake of the user event queue.
interface user_event_if;
    import user_event_queue_pkg::*;

    ev_code_t event_o;
    logic     event_ready_o;
    logic     event_rd_req_i;
    logic     overflow_o;

    modport master (output event_o, output event_ready_o, output overflow_o, input event_rd_req_i);
    modport slave  (input event_o, input event_ready_o, input overflow_o, output event_rd_req_i);
endinterface

// File: rtl/user_event_queue_button_debounce.sv
// One push-button: 2-FF synchroniser, debounce counter, debounced level and a one-cycle press pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1, sync_2;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                    press <= ~level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/user_event_queue.sv
// Push-button front end: debounce, press detection, priority arbitration into a show-ahead FIFO.
// Auto-repeat on LEFT/RIGHT/DOWN is built only when USER_EVENT_AUTOREPEAT_EN is defined.
module user_event_queue
    import user_event_queue_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BTN_CNT-1:0] btn_i,
    user_event_if.master       ev
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [BTN_CNT-1:0] level, press, repeat_set, pending, grant;
    logic               grant_valid;
    ev_code_t           grant_code;

    for (genvar b = 0; b < BTN_CNT; b++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .rst     (rst),
            .btn_raw (btn_i[b]),
            .level   (level[b]),
            .press   (press[b])
        );
    end

`ifdef USER_EVENT_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    for (genvar b = 0; b < BTN_CNT; b++) begin : g_rep
        if (REPEAT_MASK[b]) begin : g_on
            rep_state_t       state, state_nx;
            logic [REP_W-1:0] cnt, cnt_nx;
            logic             fire;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state <= REP_IDLE;
                    cnt   <= '0;
                end else begin
                    state <= state_nx;
                    cnt   <= cnt_nx;
                end
            end

            always_comb begin
                state_nx = state;
                cnt_nx   = cnt;
                fire     = 1'b0;
                if (press[b]) begin
                    state_nx = REP_DELAY;
                    cnt_nx   = '0;
                end else if (!level[b]) begin
                    state_nx = REP_IDLE;
                    cnt_nx   = '0;
                end else begin
                    case (state)
                        REP_DELAY, REP_PERIOD: begin
                            if (cnt == ((state == REP_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                                fire     = 1'b1;
                                state_nx = REP_PERIOD;
                                cnt_nx   = '0;
                            end else begin
                                cnt_nx = cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            assign repeat_set[b] = fire;
        end else begin : g_off
            assign repeat_set[b] = 1'b0;
        end
    end
`else
    assign repeat_set = '0;
`endif

    // A repeat landing on a still-pending bit simply merges into it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~grant) | (press & level) | repeat_set;
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_code  = '0;
        for (int i = 0; i < BTN_CNT; i++) begin
            if (!grant_valid && pending[BTN_PRIO[i]]) begin
                grant[BTN_PRIO[i]] = 1'b1;
                grant_valid        = 1'b1;
                grant_code         = BTN_CODE[BTN_PRIO[i]];
            end
        end
    end

    logic [AW:0] wr_ptr, rd_ptr;
    ev_code_t    mem [FIFO_DEPTH];
    ev_code_t    head;
    logic        empty, full, do_pop, do_push;
    logic        overflow;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = ev.event_rd_req_i && !empty;
    assign do_push = grant_valid && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; empty masks stale entries from the output.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= grant_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (grant_valid && !do_push)           overflow <= 1'b1;
            else if (do_pop && head == `EV_NEW_GAME) overflow <= 1'b0;
        end
    end

    assign ev.event_o       = empty ? '0 : head;
    assign ev.event_ready_o = !empty;
    assign ev.overflow_o    = overflow;
endmodule

// File: tb/tb_user_event_queue.sv
// Directed bench for user_event_queue with short debounce/repeat timings.
module tb_user_event_queue;
    import user_event_queue_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [BTN_CNT-1:0] btn;
    int                 tests    = 0;
    int                 failures = 0;

    user_event_if ev_if ();

    user_event_queue #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (8),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn),
        .ev    (ev_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pop();
        ev_if.event_rd_req_i = 1'b1;
        step();
        ev_if.event_rd_req_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 16; i++) if (ev_if.event_ready_o) pop();
    endtask

    initial begin
        rst = 1'b1;
        btn = '0;
        ev_if.event_rd_req_i = 1'b0;
        step(2);
        check("rst_event", 32'(ev_if.event_o), 32'd0);
        check("rst_ready", 32'(ev_if.event_ready_o), 32'd0);
        check("rst_ovf", 32'(ev_if.overflow_o), 32'd0);
        rst = 1'b0;
        step(2);

        // Clean LEFT press
        btn[BTN_LEFT] = 1'b1;
        step(7);
        check("left_lat_m1", 32'(ev_if.event_ready_o), 32'd0);
        step();
        check("left_ready", 32'(ev_if.event_ready_o), 32'd1);
        check("left_code", 32'(ev_if.event_o), 32'(`EV_LEFT));
        pop();
        check("left_popped", 32'(ev_if.event_ready_o), 32'd0);
        step(21);
        btn[BTN_LEFT] = 1'b0;
        step(10);
`ifndef USER_EVENT_AUTOREPEAT_EN
        check("left_no_repeat", 32'(ev_if.event_ready_o), 32'd0);
`endif
        drain();

        // Bouncing ROTATE: five toggles two cycles apart, ending high
        for (int k = 0; k < 5; k++) begin
            btn[BTN_ROTATE] = (k % 2 == 0);
            if (k < 4) step(2);
        end
        step(7);
        check("rot_lat_m1", 32'(ev_if.event_ready_o), 32'd0);
        step();
        check("rot_ready", 32'(ev_if.event_ready_o), 32'd1);
        check("rot_code", 32'(ev_if.event_o), 32'(`EV_ROTATE));
        pop();
        check("rot_single", 32'(ev_if.event_ready_o), 32'd0);
        btn[BTN_ROTATE] = 1'b0;
        step(10);
        check("rot_release", 32'(ev_if.event_ready_o), 32'd0);

        // All five at once: four queued in priority order, RIGHT dropped
        btn = 5'b11111;
        step(8);
        check("sim_head", 32'(ev_if.event_o), 32'(`EV_NEW_GAME));
        check("sim_ovf_early", 32'(ev_if.overflow_o), 32'd0);
        step(3);
        check("sim_ovf_full", 32'(ev_if.overflow_o), 32'd0);
        step();
        check("sim_ovf_drop", 32'(ev_if.overflow_o), 32'd1);
        btn = '0;
        step(10);
        check("sim_head_hold", 32'(ev_if.event_o), 32'(`EV_NEW_GAME));
        check("sim_ovf_sticky", 32'(ev_if.overflow_o), 32'd1);
        pop();
        check("sim_second", 32'(ev_if.event_o), 32'(`EV_ROTATE));
        check("ovf_clr_newgame", 32'(ev_if.overflow_o), 32'd0);

        // Queue is ROTATE, DOWN, LEFT; RIGHT fills it, LEFT then overflows
        btn[BTN_RIGHT] = 1'b1;
        step(8);
        btn = '0;
        step(10);
        check("fill_ovf", 32'(ev_if.overflow_o), 32'd0);
        btn[BTN_LEFT] = 1'b1;
        step(8);
        check("full_drop_ovf", 32'(ev_if.overflow_o), 32'd1);
        check("full_drop_head", 32'(ev_if.event_o), 32'(`EV_ROTATE));
        btn = '0;
        step(10);

        // Full FIFO: DOWN pushed in the same cycle ROTATE is popped
        btn[BTN_DOWN] = 1'b1;
        step(7);
        pop();
        btn = '0;
        check("cc_ovf_kept", 32'(ev_if.overflow_o), 32'd1);
        check("cc_head", 32'(ev_if.event_o), 32'(`EV_DOWN));
        pop();
        check("cc_e2", 32'(ev_if.event_o), 32'(`EV_LEFT));
        pop();
        check("cc_e3", 32'(ev_if.event_o), 32'(`EV_RIGHT));
        pop();
        check("cc_tail", 32'(ev_if.event_o), 32'(`EV_DOWN));
        check("cc_ready4", 32'(ev_if.event_ready_o), 32'd1);
        pop();
        check("cc_empty", 32'(ev_if.event_ready_o), 32'd0);
        check("cc_ovf_end", 32'(ev_if.overflow_o), 32'd1);
        step(10);

        // Reset with three events queued and DOWN held through it
        btn = 5'b00111;
        step(12);
        check("pre_rst_head", 32'(ev_if.event_o), 32'(`EV_DOWN));
        btn = 5'b00100;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ev_if.event_ready_o), 32'd0);
        check("mid_rst_event", 32'(ev_if.event_o), 32'd0);
        check("mid_rst_ovf", 32'(ev_if.overflow_o), 32'd0);
        step(3);
        check("mid_rst_hold", 32'(ev_if.event_ready_o), 32'd0);
        rst = 1'b0;
        step(7);
        check("post_rst_m1", 32'(ev_if.event_ready_o), 32'd0);
        step();
        check("post_rst_ready", 32'(ev_if.event_ready_o), 32'd1);
        check("post_rst_code", 32'(ev_if.event_o), 32'(`EV_DOWN));
        btn = '0;
        drain();
        step(10);
        drain();
        check("post_rst_empty", 32'(ev_if.event_ready_o), 32'd0);

`ifdef USER_EVENT_AUTOREPEAT_EN
        // RIGHT held 60 cycles, consumer pops every event as soon as it shows
        btn[BTN_RIGHT] = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            logic exp_rdy;
            step();
            exp_rdy = (n == 8) || (n == 28) || (n == 36) || (n == 44) || (n == 52) || (n == 60);
            check($sformatf("rep_ready_c%0d", n), 32'(ev_if.event_ready_o), 32'(exp_rdy));
            if (exp_rdy) check($sformatf("rep_code_c%0d", n), 32'(ev_if.event_o), 32'(`EV_RIGHT));
            ev_if.event_rd_req_i = ev_if.event_ready_o;
            if (n == 60) btn[BTN_RIGHT] = 1'b0;
        end
        ev_if.event_rd_req_i = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/user_event_queue.md
Name: user_event_queue

Overview:
- Upstream stage of the game-logic FSM. Turns five raw, asynchronous push-buttons (LEFT, RIGHT, DOWN, ROTATE, NEW_GAME) into a queue of 3-bit user-event codes.
- Per-button processing: synchroniser, debounce, press-edge detection and optional auto-repeat.
- Events are arbitrated into a small show-ahead FIFO.
- The consumer sees the head event plus a ready flag, and pops the head with a read request.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronised samples required before the debounced level changes.
- REPEAT_DELAY, 12500000: cycles a button must be held after its press event before the first repeat event.
- REPEAT_PERIOD, 2500000: cycles between successive repeat events while the button is held.
- FIFO_DEPTH, 4: event queue entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- btn_i  in  5  raw button levels, active-high; bit 0 LEFT, 1 RIGHT, 2 DOWN, 3 ROTATE, 4 NEW_GAME
- event_o  out  3  head-of-queue event code (`EV_LEFT / `EV_RIGHT / `EV_DOWN / `EV_ROTATE / `EV_NEW_GAME)
- event_ready_o  out  1  queue non-empty; event_o valid
- event_rd_req_i  in  1  pop head; honoured only when event_ready_o=1
- overflow_o  out  1  sticky: an event was dropped because the queue was full

Behaviour:
- Reset (rst asynchronous, active-high; clock clk):
  - All synchroniser, debounce, repeat and pending state clears.
  - Debounced levels reset to 0 (released).
  - FIFO empty; outputs are event_o=0, event_ready_o=0, overflow_o=0.
  - A button held through reset generates one press event once debounced.
- Synchronisation and debounce:
  - Each btn_i bit passes through a 2-FF synchroniser.
  - A per-button counter increments while the synchronised level differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
- Press detection: a debounced 0->1 transition sets that button's pending bit.
- Release: a 1->0 transition generates no event and stops repeat for that button.
- Arbitration (one cycle per event):
  - Each cycle at most one pending bit is granted, by fixed priority NEW_GAME > ROTATE > DOWN > LEFT > RIGHT.
  - The granted pending bit clears and its code is pushed.
  - Simultaneous presses therefore enter the FIFO on consecutive cycles, in priority order.
- Latency: a raw level change held stable until debounced shows up as event_ready_o=1 exactly DEBOUNCE_CYCLES+4 cycles later, provided the FIFO was empty and no higher-priority event was pending.
- FIFO:
  - Show-ahead: event_o always reflects the head.
  - Pop when event_rd_req_i && event_ready_o; event_rd_req_i while empty is ignored.
  - Push when full without a same-cycle pop: the new event is dropped, its pending bit still clears, and overflow_o sets.
  - Push when full with a same-cycle pop: the push succeeds.
  - Push while empty: event_ready_o rises the following cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty come from MSB comparison.
- overflow_o clears only on rst, or on a pop of an `EV_NEW_GAME event.
- Event codes come only from the shared `EV_* defines; no other codes are ever emitted.

Optional Feature:
- Macro USER_EVENT_AUTOREPEAT_EN.
- Defined:
  - LEFT, RIGHT and DOWN each have a repeat counter, started at their press event.
  - After REPEAT_DELAY cycles held, the pending bit is set again; thereafter it is set every REPEAT_PERIOD cycles until release.
  - ROTATE and NEW_GAME never repeat.
  - A repeat that finds its pending bit still set is merged, not queued twice.
- Not defined: no repeat counters are synthesised; exactly one event per debounced press.

Decomposition:
- Shared package/defines:
  - button index constants (BTN_LEFT..BTN_NEW_GAME, BTN_CNT=5);
  - event code width (3), reusing the existing `EV_* values;
  - the fixed priority order as a constant list.
- Natural sub-module: button_debounce, one instance per button. It contains the synchroniser and debounce counter, and outputs the debounced level plus a one-cycle press pulse.
- The FIFO stays inline.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, FIFO_DEPTH=4):
- Clean press: btn_i[0] rises and is held for 30 cycles -> event_ready_o=1 at cycle 8 with event_o=`EV_LEFT; one pop -> event_ready_o=0; no further events with autorepeat off.
- Bounce: btn_i[3] toggles every 2 cycles for 10 cycles, then is held high -> exactly one `EV_ROTATE, appearing 8 cycles after the last toggle.
- Simultaneous: btn_i=5'b11111 in one cycle, no pops -> queue holds NEW_GAME, ROTATE, DOWN, LEFT; RIGHT is dropped; overflow_o=1.
- Full with concurrent pop: FIFO full, a push and a pop in the same cycle -> occupancy stays 4, new event is at the tail, overflow_o unchanged.
- Reset mid-operation: rst asserted with 3 events queued and btn_i[2] held -> all outputs 0 during reset; after release, one `EV_DOWN appears after DEBOUNCE_CYCLES+4 cycles.
- Autorepeat (macro defined): hold btn_i[1] for 60 cycles with the consumer popping every cycle -> `EV_RIGHT events at cycles 8, 28, 36, 44, 52, 60 relative to the raw rise.
